// File: rtl/lane_pkg.sv
// -----------------------------------------------------------------------------
// lane_pkg
// Constants and types shared by the lane renderer and its scan counter:
// lane geometry, the lane colour palette and the renderer state encoding.
// -----------------------------------------------------------------------------
package lane_pkg;

   localparam int LANE_COUNT = 3;
   localparam int LANE_ROWS  = 120;
   localparam int DATA_W     = LANE_COUNT * LANE_ROWS;

   localparam logic [2:0] COL_DO  = 3'b100;
   localparam logic [2:0] COL_RE  = 3'b010;
   localparam logic [2:0] COL_MI  = 3'b001;
   localparam logic [2:0] COL_BG  = 3'b000;
   localparam logic [2:0] COL_HIT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DRAW = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Colour of an active note in the given lane.
   function automatic logic [2:0] lane_colour(input logic [1:0] lane);
      case (lane)
         2'd0:    return COL_DO;
         2'd1:    return COL_RE;
         default: return COL_MI;
      endcase
   endfunction

endpackage

// File: rtl/lane_scan_counter.sv
// -----------------------------------------------------------------------------
// lane_scan_counter
// Nested col -> row -> lane pixel counter. Column counts fastest and wraps at
// LANE_W-1, carrying into row (wraps at 119), which carries into lane (0..2).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      synchronous clear to (col,row,lane) = (0,0,0); wins over en_i
//   en_i         advance one pixel
//   col_o/row_o/lane_o  current position
//   last_o       high while the position is the final pixel of the frame
// -----------------------------------------------------------------------------
module lane_scan_counter
   import lane_pkg::*;
#(
   parameter int LANE_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   input  logic       en_i,
   output logic [7:0] col_o,
   output logic [6:0] row_o,
   output logic [1:0] lane_o,
   output logic       last_o
);

   localparam logic [7:0] COL_LAST  = 8'(LANE_W - 1);
   localparam logic [6:0] ROW_LAST  = 7'(LANE_ROWS - 1);
   localparam logic [1:0] LANE_LAST = 2'(LANE_COUNT - 1);

   logic [7:0] col_q, col_d;
   logic [6:0] row_q, row_d;
   logic [1:0] lane_q, lane_d;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         row_q  <= '0;
         lane_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         lane_q <= lane_d;
      end
   end

   // NOTE: every combinational output starts from a default (hold) so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      lane_d = lane_q;
      if (clear_i) begin
         col_d  = '0;
         row_d  = '0;
         lane_d = '0;
      end else if (en_i) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
               row_d  = '0;
               lane_d = (lane_q == LANE_LAST) ? 2'd0 : lane_q + 2'd1;
            end else begin
               row_d = row_q + 7'd1;
            end
         end else begin
            col_d = col_q + 8'd1;
         end
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign lane_o = lane_q;
   assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST) && (lane_q == LANE_LAST);

endmodule

// File: rtl/lane_renderer.sv
// -----------------------------------------------------------------------------
// lane_renderer
// Draws the three note lanes (do/re/mi, 120 rows each) into a VGA adapter, one
// registered pixel write per cycle. The lane bits are captured at frame start
// so a shift of the input mid-frame cannot tear the picture.
// Ports:
//   clock, resetn   clock, asynchronous active-low reset
//   frame_tick      one-cycle request for a redraw; one extra request may be
//                   queued while a frame is in progress, further ones drop
//   data[359:0]     lane L row R at data[L*120+R], row 0 at the top
//   x, y, colour    pixel coordinate and colour, valid while plot is high
//   plot            pixel write strobe
//   busy            frame in progress
//   frame_done      one-cycle pulse after the last pixel
// Build option:
//   LANE_RENDERER_HIT_LINE_EN  draw empty cells of row HIT_ROW in white
// -----------------------------------------------------------------------------
module lane_renderer
   import lane_pkg::*;
#(
   parameter int LANE_W     = 8,
   parameter int LANE_X0    = 50,
   parameter int LANE_PITCH = 20,
   parameter int HIT_ROW    = 110
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              frame_tick,
   input  logic [DATA_W-1:0] data,
   output logic [7:0]        x,
   output logic [6:0]        y,
   output logic [2:0]        colour,
   output logic              plot,
   output logic              busy,
   output logic              frame_done
);

`ifdef LANE_RENDERER_HIT_LINE_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] snap_q, snap_d;
   logic              pending_q, pending_d;
   logic [7:0]        x_q, x_d;
   logic [6:0]        y_q, y_d;
   logic [2:0]        colour_q, colour_d;
   logic              plot_q, plot_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [7:0]        scan_col;
   logic [6:0]        scan_row;
   logic [1:0]        scan_lane;
   logic              scan_last;
   logic [8:0]        bit_idx;
   logic              snap_bit;
   logic [2:0]        pix_colour;

   lane_scan_counter #(.LANE_W(LANE_W)) u_scan (
      .clk     (clock),
      .rst_n   (resetn),
      .clear_i (state_q == ST_LOAD),
      .en_i    (state_q == ST_DRAW),
      .col_o   (scan_col),
      .row_o   (scan_row),
      .lane_o  (scan_lane),
      .last_o  (scan_last)
   );

   assign bit_idx  = (9'(scan_lane) * 9'(LANE_ROWS)) + 9'(scan_row);
   assign snap_bit = snap_q[bit_idx];

   // Active notes always keep their lane colour; the hit line only fills gaps.
   assign pix_colour = snap_bit ? lane_colour(scan_lane) :
                       (HIT_EN && (scan_row == 7'(HIT_ROW))) ? COL_HIT : COL_BG;

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next state. A tick arriving in DONE is treated like a queued one.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (frame_tick) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_DRAW;
         ST_DRAW: if (scan_last) state_d = ST_DONE;
         ST_DONE: state_d = (pending_q || frame_tick) ? ST_LOAD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values; pixel outputs hold between writes.
   always_comb begin
      snap_d    = snap_q;
      pending_d = pending_q;
      x_d       = x_q;
      y_d       = y_q;
      colour_d  = colour_q;
      plot_d    = 1'b0;
      done_d    = 1'b0;
      busy_d    = (state_d != ST_IDLE);
      case (state_q)
         ST_LOAD: snap_d = data;
         ST_DRAW: begin
            plot_d   = 1'b1;
            x_d      = 8'(LANE_X0) + (8'(scan_lane) * 8'(LANE_PITCH)) + scan_col;
            y_d      = scan_row;
            colour_d = pix_colour;
         end
         ST_DONE: done_d = 1'b1;
         default: ;
      endcase
      if (state_q == ST_DONE)                     pending_d = 1'b0;
      else if (frame_tick && state_q != ST_IDLE)  pending_d = 1'b1;
   end

   // NOTE: the 360-bit snapshot is a flop vector, not a RAM, so it is reset
   // together with the rest of the state at no real cost.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         snap_q    <= '0;
         pending_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         colour_q  <= '0;
         plot_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         snap_q    <= snap_d;
         pending_q <= pending_d;
         x_q       <= x_d;
         y_q       <= y_d;
         colour_q  <= colour_d;
         plot_q    <= plot_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign colour     = colour_q;
   assign plot       = plot_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_lane_renderer.sv
// -----------------------------------------------------------------------------
// tb_lane_renderer
// Directed stimulus for lane_renderer. A frame-level reference model predicts
// plot/busy/frame_done per cycle and the full pixel stream of every frame from
// the captured lane bits; a compare process checks the DUT against it on each
// falling edge. Hand-computed literals pin latency, geometry and colours.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lane_renderer;

   localparam int LANE_W     = 8;
   localparam int LANE_X0    = 50;
   localparam int LANE_PITCH = 20;
   localparam int HIT_ROW    = 110;
   localparam int ROWS       = 120;
   localparam int FRAME_PIX  = 3 * ROWS * LANE_W;   // 2880
`ifdef LANE_RENDERER_HIT_LINE_EN
   localparam bit HIT = 1'b1;
`else
   localparam bit HIT = 1'b0;
`endif
   localparam int HIT_PIX = HIT ? 3 * LANE_W : 0;

   logic         clock      = 1'b0;
   logic         resetn     = 1'b0;
   logic         frame_tick = 1'b0;
   logic [359:0] data       = '0;
   logic [7:0]   x;
   logic [6:0]   y;
   logic [2:0]   colour;
   logic         plot, busy, frame_done;

   lane_renderer #(
      .LANE_W(LANE_W), .LANE_X0(LANE_X0), .LANE_PITCH(LANE_PITCH), .HIT_ROW(HIT_ROW)
   ) dut (
      .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .data(data),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .frame_done(frame_done)
   );

   always #10 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int px; int py; int pc; } pix_t;
   pix_t exp_q[$];

   int cyc        = 0;
   bit m_active   = 1'b0;
   bit m_pend     = 1'b0;
   int m_load     = -100000;   // cycle in which the current frame snapshots
   int m_done_cyc = -100000;   // cycle in which frame_done must be seen
   bit m_prev_busy, m_prev_last, m_start;

   // Pixel stream of one frame: lanes, then rows, then columns, from snapshot s.
   task automatic build_frame(input logic [359:0] s);
      exp_q.delete();
      for (int l = 0; l < 3; l++)
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < LANE_W; c++) begin
               pix_t p;
               p.px = LANE_X0 + l * LANE_PITCH + c;
               p.py = r;
               if (s[l * ROWS + r])          p.pc = 4 >> l;
               else if (HIT && r == HIT_ROW) p.pc = 7;
               else                          p.pc = 0;
               exp_q.push_back(p);
            end
   endtask

   // Frame timing: snapshot in cycle L, plots in L+2 .. L+FRAME_PIX+1,
   // busy over L .. L+FRAME_PIX+1, frame_done in L+FRAME_PIX+2.
   always @(posedge clock) begin
      cyc++;
      if (!resetn) begin
         m_active   = 1'b0;
         m_pend     = 1'b0;
         m_done_cyc = -100000;
         exp_q.delete();
      end else begin
         if (m_active && cyc - 1 == m_load) build_frame(data);
         m_prev_busy = m_active && (cyc - 1 >= m_load) && (cyc - 1 <= m_load + FRAME_PIX + 1);
         m_prev_last = m_active && (cyc - 1 == m_load + FRAME_PIX + 1);
         m_start     = 1'b0;
         if (m_prev_last) m_done_cyc = cyc;
         if (frame_tick && (!m_prev_busy || m_prev_last)) m_start = 1'b1;
         else if (frame_tick && !m_pend)                  m_pend  = 1'b1;
         if (m_prev_last && m_pend) m_start = 1'b1;
         if (m_start) begin
            m_active = 1'b1;
            m_load   = cyc;
            m_pend   = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit e_plot, e_busy, e_done;
   always @(negedge clock) begin
      if (!resetn) begin
         check("rst_plot", plot, 0);
         check("rst_busy", busy, 0);
         check("rst_done", frame_done, 0);
         check("rst_x", x, 0);
         check("rst_y", y, 0);
         check("rst_colour", colour, 0);
      end else begin
         e_plot = m_active && (cyc >= m_load + 2) && (cyc <= m_load + FRAME_PIX + 1);
         e_busy = m_active && (cyc >= m_load) && (cyc <= m_load + FRAME_PIX + 1);
         e_done = (cyc == m_done_cyc);
         check("plot", plot, e_plot);
         check("busy", busy, e_busy);
         check("frame_done", frame_done, e_done);
         if (e_plot) begin
            if (exp_q.size() == 0) check("pixel_underrun", 1, 0);
            else begin
               pix_t p;
               p = exp_q.pop_front();
               check("x", x, p.px);
               check("y", y, p.py);
               check("colour", colour, p.pc);
            end
         end
      end
   end

   // ---------------- capture of DUT output for literal checks ----------------
   int plot_cnt, done_cnt, first_x, first_y, last_x, last_y;
   bit prev_plot;
   int rise_cyc[$];
   int done_cyc[$];
   logic [2:0] img [0:159][0:119];

   always @(negedge clock) begin
      if (resetn) begin
         if (plot) begin
            if (!prev_plot) rise_cyc.push_back(cyc);
            if (plot_cnt == 0) begin first_x = x; first_y = y; end
            img[x][y] = colour;
            plot_cnt++;
            last_x = x;
            last_y = y;
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
         end
         prev_plot = plot;
      end
   end

   task automatic clear_stats();
      plot_cnt = 0; done_cnt = 0; prev_plot = 1'b0;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1;
      rise_cyc.delete();
      done_cyc.delete();
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) img[i][j] = 3'b000;
   endtask

   function automatic int lit_count();
      int n = 0;
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) if (img[i][j] != 3'b000) n++;
      return n;
   endfunction

   // ---------------- stimulus helpers (always return at posedge + 1) ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k = 0;
      while (done_cnt < target && k < budget) begin step(1); k++; end
      if (done_cnt < target) check({name, "_timeout"}, done_cnt, target);
   endtask

   task automatic wait_plots(input int target, input int budget, input string name);
      int k = 0;
      while (plot_cnt < target && k < budget) begin step(1); k++; end
      if (plot_cnt < target) check({name, "_timeout"}, plot_cnt, target);
   endtask

   int tick_cyc;

   initial begin
      clear_stats();
      step(3);
      check("reset_busy", busy, 0);
      check("reset_plot", plot, 0);
      resetn = 1'b1;
      step(2);

      // 1: empty lanes, latency and geometry
      data = '0;
      clear_stats();
      tick_cyc = cyc;
      pulse_tick();
      wait_done(1, 4000, "t1");
      step(5);
      check("t1_latency", (rise_cyc.size() > 0) ? rise_cyc[0] - (tick_cyc + 1) : -1, 2);
      check("t1_plots", plot_cnt, 2880);
      check("t1_runs", rise_cyc.size(), 1);
      check("t1_first_x", first_x, 50);
      check("t1_first_y", first_y, 0);
      check("t1_last_x", last_x, 97);
      check("t1_last_y", last_y, 119);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_done_gap", (done_cyc.size() > 0 && rise_cyc.size() > 0) ? done_cyc[0] - rise_cyc[0] : -1, 2880);
      check("t1_lit", lit_count(), HIT_PIX);
      check("t1_hit_row_l0", img[50][110], HIT ? 7 : 0);
      check("t1_hit_row_l2", img[97][110], HIT ? 7 : 0);
      check("t1_row109", img[50][109], 0);

      // 2: one note per lane
      data = '0;
      data[0] = 1'b1; data[125] = 1'b1; data[359] = 1'b1;
      clear_stats();
      pulse_tick();
      wait_done(1, 4000, "t2");
      step(5);
      for (int c = 0; c < LANE_W; c++) begin
         check("t2_do", img[50 + c][0], 3'b100);
         check("t2_re", img[70 + c][5], 3'b010);
         check("t2_mi", img[90 + c][119], 3'b001);
      end
      check("t2_lit", lit_count(), 24 + HIT_PIX);

      // 3: data cleared early in DRAW; snapshot must hold
      data = '0;
      data[0] = 1'b1;
      clear_stats();
      pulse_tick();
      wait_plots(3, 100, "t3");
      data = '0;
      wait_done(1, 4000, "t3");
      step(5);
      for (int c = 0; c < LANE_W; c++) check("t3_snap", img[50 + c][0], 3'b100);

      // 4: two extra ticks mid-frame queue exactly one frame; second frame
      //    snapshots the data present at its own start
      data = '0;
      data[2] = 1'b1;
      clear_stats();
      pulse_tick();
      wait_plots(100, 200, "t4a");
      pulse_tick();
      wait_plots(200, 200, "t4b");
      pulse_tick();
      data = '0;
      data[1] = 1'b1;
      wait_done(2, 7000, "t4");
      step(20);
      check("t4_plots", plot_cnt, 5760);
      check("t4_done_cnt", done_cnt, 2);
      check("t4_runs", rise_cyc.size(), 2);
      check("t4_restart", (rise_cyc.size() > 1 && done_cyc.size() > 0) ? rise_cyc[1] - done_cyc[0] : -1, 2);
      check("t4_new_snap", img[50][1], 3'b100);
      check("t4_old_gone", img[50][2], 3'b000);
      check("t4_idle_busy", busy, 0);

      // 5: reset mid-frame aborts without frame_done
      data = '0;
      data[0] = 1'b1;
      clear_stats();
      pulse_tick();
      wait_plots(1000, 1100, "t5");
      resetn = 1'b0;
      #1;
      check("t5_abort_plot", plot, 0);
      check("t5_abort_busy", busy, 0);
      check("t5_abort_done", frame_done, 0);
      step(3);
      resetn = 1'b1;
      step(50);
      check("t5_no_done", done_cnt, 0);
      check("t5_no_plots", plot_cnt, 1000);
      check("t5_idle_busy", busy, 0);
      clear_stats();
      pulse_tick();
      wait_done(1, 4000, "t5r");
      step(5);
      check("t5_recover_plots", plot_cnt, 2880);
      check("t5_recover_do", img[57][0], 3'b100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_renderer.md
Name: lane_renderer

Overview:
- Downstream of the lane-data shifter. Consumes its 360-bit strip vector: 3 lanes (do/re/mi) x 120 rows.
- Walks every pixel of the three lanes once per frame tick and emits one pixel write per cycle (x, y, colour, plot) to the VGA adapter.
- Snapshots the data at frame start, so a mid-frame shift never tears the picture.

Parameters:
- LANE_W, 8, pixel width of one lane column
- LANE_X0, 50, x of lane 0 left edge
- LANE_PITCH, 20, x distance between lane left edges; must be >= LANE_W
- HIT_ROW, 110, row of hit line (used only with HIT_LINE_EN)

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  single-cycle pulse per display update (0.02 s), synchronous to clock
- data  in  360  lane bits; lane L row R = data[L*120+R]; row 0 = top
- x  out  8  pixel x
- y  out  7  pixel y (0..119)
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe; x/y/colour valid when high
- busy  out  1  high from LOAD through the last DRAW cycle
- frame_done  out  1  single-cycle pulse after the last pixel

Behaviour:
- Reset (async, resetn=0): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, frame_done=0, snapshot=0, pending=0, all counters 0.
- States: IDLE, LOAD, DRAW, DONE.
- IDLE: frame_tick=1 -> LOAD.
- LOAD (1 cycle):
  - snap <= data.
  - col=0, row=0, lane=0.
  - busy=1.
  - Goes to DRAW.
- DRAW: each cycle registers one pixel and sets plot=1:
  - x = LANE_X0 + lane*LANE_PITCH + col.
  - y = row.
  - colour = snap bit ? lane colour : 3'b000.
  - Lane colours: do 3'b100, re 3'b010, mi 3'b001.
- Scan order:
  - col increments first, wrapping at LANE_W-1.
  - Then row, wrapping at 119.
  - Then lane, 0..2.
- On the last pixel (lane=2, row=119, col=LANE_W-1) -> DONE.
- DONE (1 cycle):
  - plot=0, frame_done=1, busy=0.
  - If pending=1: clear pending -> LOAD. Otherwise -> IDLE.
- Latency:
  - tick sampled at edge N -> LOAD during cycle N+1.
  - First plot high after edge N+2.
  - Exactly 3*120*LANE_W plot cycles per frame (2880 at default), contiguous, no gaps.
- plot=0 in IDLE, LOAD and DONE.
- frame_tick while busy or in DONE sets pending (one deep). Further ticks are dropped.
- The snapshot never changes during DRAW. data changes mid-frame are ignored.
- x arithmetic is 8-bit. Legal parameters keep x <= 159; no wrap check in RTL.
- resetn asserted mid-frame:
  - Immediate abort to IDLE with outputs at reset values.
  - No frame_done.
  - pending cleared.

Optional Feature:
- Macro: LANE_RENDERER_HIT_LINE_EN.
- Defined: on row HIT_ROW, any pixel whose snap bit is 0 is drawn 3'b111 (white hit line). Active notes still show the lane colour. Timing is unchanged.
- Undefined: row HIT_ROW is drawn like every other row.

Decomposition:
- Shared package (lane_pkg):
  - LANE_COUNT=3, LANE_ROWS=120.
  - Colour constants: COL_DO, COL_RE, COL_MI, COL_BG, COL_HIT.
  - State encoding for IDLE/LOAD/DRAW/DONE.
- Sub-module lane_scan_counter:
  - Nested col/row/lane counter with clear, enable and a last-pixel flag.
  - Also reused by the hit-detection block.

Test Plan:
- Reset, then data=0 and one frame_tick:
  - plot rises 2 cycles after the tick.
  - 2880 consecutive plot cycles, all colour=0.
  - First pixel (50,0); last pixel (97,119).
  - frame_done pulses once; busy falls with it.
- data[0]=1, data[125]=1, data[359]=1, one tick:
  - (50..57, 0) = 3'b100.
  - (70..77, 5) = 3'b010.
  - (90..97, 119) = 3'b001.
  - Every other pixel = 0.
- Tick with data[0]=1; data changed to 0 at DRAW cycle 3: all of (50..57, 0) still 3'b100.
- Second tick at DRAW cycle 100, third at cycle 200:
  - Exactly one extra frame starts in the cycle after frame_done (LOAD).
  - Total 5760 plots and two frame_done pulses.
- resetn low at DRAW cycle 1000:
  - plot/busy go 0 asynchronously and frame_done never pulses.
  - After release, nothing happens until the next tick.
- With LANE_RENDERER_HIT_LINE_EN and data=0: row 110 pixels are 3'b111 and all other rows are 0. Without the macro, row 110 is 0.
